// File: rtl/bldc_duty_ramp.sv
// Command-side duty slew and reversal sequencer in front of the table-driven BLDC driver.
// Optional feature: define BLDC_DUTY_RAMP_MIN_DUTY_EN to enable the min_duty floor on ramps.
module bldc_duty_ramp #(
    parameter int unsigned clk_freq_hz     = 54_000_000,
    parameter int unsigned duty_width      = 11,
    parameter int unsigned counter_width   = 32,
    parameter int unsigned max_duty        = 1000,
    parameter int unsigned ramp_step       = 1,
    parameter int unsigned ramp_step_us    = 10,
    parameter int unsigned stop_rpm        = 30,
    parameter int unsigned stop_timeout_ms = 500,
    parameter int unsigned min_duty        = 80
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_enable,
    input  logic [1:0]               cmd_direction,
    input  logic [duty_width-1:0]    cmd_duty,
    input  logic [counter_width-1:0] rpm,
    input  logic [2:0]               driver_state,
    input  logic                     hall_error,
    output logic                     enable,
    output logic [1:0]               direction,
    output logic [duty_width-1:0]    pwm_duty,
    output logic                     ramp_active,
    output logic [2:0]               ramp_state
);

    localparam int unsigned TICK_DIV    = (clk_freq_hz / 1_000_000) * ramp_step_us;
    localparam int unsigned PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TIMEOUT_CYC = (clk_freq_hz / 1000) * stop_timeout_ms;
    localparam int unsigned TW          = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [PW-1:0]            TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0]            TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [duty_width-1:0]    MAX_D     = duty_width'(max_duty);
    localparam logic [duty_width:0]      STEP_X    = (duty_width + 1)'(ramp_step);
    localparam logic [counter_width-1:0] STOP_RPM  = counter_width'(stop_rpm);
`ifdef BLDC_DUTY_RAMP_MIN_DUTY_EN
    localparam logic [duty_width-1:0]    MIN_D     = duty_width'(min_duty);
`endif
    localparam logic [1:0]               DIR_NONE  = 2'd0;
    localparam logic [2:0]               DRV_ERROR = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP      = 3'd1,
        S_HOLD      = 3'd2,
        S_BRAKE     = 3'd3,
        S_WAIT_STOP = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    function automatic logic [duty_width-1:0] clamp_target(input logic [duty_width-1:0] d);
        logic [duty_width-1:0] t;
        t = (d > MAX_D) ? MAX_D : d;
`ifdef BLDC_DUTY_RAMP_MIN_DUTY_EN
        if (t != '0 && t < MIN_D) t = MIN_D;
`endif
        return t;
    endfunction

    // One step toward tgt; arithmetic is one bit wider so overflow/underflow saturate at tgt.
    function automatic logic [duty_width-1:0] ramp_next(input logic [duty_width-1:0] cur,
                                                        input logic [duty_width-1:0] tgt);
        logic [duty_width:0]   up;
        logic [duty_width:0]   dn;
        logic [duty_width-1:0] nxt;
        up  = {1'b0, cur} + STEP_X;
        dn  = {1'b0, cur} - STEP_X;
        nxt = cur;
        if (cur < tgt) begin
            nxt = (up >= {1'b0, tgt}) ? tgt : up[duty_width-1:0];
`ifdef BLDC_DUTY_RAMP_MIN_DUTY_EN
            if (cur == '0) nxt = (tgt < MIN_D) ? tgt : MIN_D;
`endif
        end else if (cur > tgt) begin
            nxt = (dn[duty_width] || dn[duty_width-1:0] <= tgt) ? tgt : dn[duty_width-1:0];
`ifdef BLDC_DUTY_RAMP_MIN_DUTY_EN
            if (nxt < MIN_D) nxt = '0;
`endif
        end
        return nxt;
    endfunction

    state_t                  state_q, state_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [TW-1:0]           wait_q, wait_d;
    logic                    enable_q, enable_d;
    logic [1:0]              dir_q, dir_d;
    logic [1:0]              pend_dir_q, pend_dir_d;
    logic [duty_width-1:0]   duty_q, duty_d;
    logic [duty_width-1:0]   target_q, target_d;
    logic [duty_width-1:0]   cmd_tgt_q, cmd_tgt_d;
    logic                    ramp_active_q, ramp_active_d;
    logic                    ready_q, ready_d;

    logic                    tick;
    logic                    accept;
    logic                    fault;
    logic [duty_width-1:0]   new_tgt;
    logic [duty_width-1:0]   step_duty;

    always_comb begin
        tick      = (presc_q == TICK_LAST);
        accept    = cmd_valid & ready_q;
        fault     = hall_error | (driver_state == DRV_ERROR);
        new_tgt   = clamp_target(cmd_duty);
        step_duty = ramp_next(duty_q, target_q);

        state_d    = state_q;
        presc_d    = tick ? '0 : presc_q + 1'b1;
        wait_d     = '0;
        enable_d   = enable_q;
        dir_d      = dir_q;
        pend_dir_d = pend_dir_q;
        duty_d     = duty_q;
        target_d   = target_q;
        cmd_tgt_d  = cmd_tgt_q;

        if (fault) begin
            state_d  = S_FAULT;
            enable_d = 1'b0;
            dir_d    = DIR_NONE;
            duty_d   = '0;
            target_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept && cmd_enable && cmd_direction != DIR_NONE && new_tgt != '0) begin
                        state_d   = S_RAMP;
                        enable_d  = 1'b1;
                        dir_d     = cmd_direction;
                        target_d  = new_tgt;
                        cmd_tgt_d = new_tgt;
                    end
                end
                S_RAMP, S_HOLD: begin
                    if (accept && !cmd_enable) begin
                        state_d  = S_IDLE;
                        enable_d = 1'b0;
                        dir_d    = DIR_NONE;
                        duty_d   = '0;
                        target_d = '0;
                    end else if (accept && cmd_direction != DIR_NONE && cmd_direction != dir_q) begin
                        pend_dir_d = cmd_direction;
                        cmd_tgt_d  = new_tgt;
                        target_d   = '0;
                        if (duty_q != '0) begin
                            state_d = S_BRAKE;
                        end else begin
                            state_d  = S_WAIT_STOP;
                            enable_d = 1'b0;
                        end
                    end else if (accept) begin
                        target_d  = new_tgt;
                        cmd_tgt_d = new_tgt;
                        state_d   = (duty_q == new_tgt) ? S_HOLD : S_RAMP;
                    end else if (state_q == S_RAMP) begin
                        if (tick) duty_d = step_duty;
                        state_d = (duty_d == target_q) ? S_HOLD : S_RAMP;
                    end
                end
                S_BRAKE: begin
                    if (tick) duty_d = step_duty;
                    if (duty_d == '0) begin
                        state_d  = S_WAIT_STOP;
                        enable_d = 1'b0;
                    end
                end
                S_WAIT_STOP: begin
                    // Swap once the motor is slow enough, or give up waiting after the timeout.
                    if (rpm <= STOP_RPM || wait_q == TO_LAST) begin
                        state_d  = S_RAMP;
                        enable_d = 1'b1;
                        dir_d    = pend_dir_q;
                        target_d = cmd_tgt_q;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                S_FAULT: begin
                    if (accept && !cmd_enable) state_d = S_IDLE;
                end
                default: begin
                    state_d  = S_IDLE;
                    enable_d = 1'b0;
                    dir_d    = DIR_NONE;
                    duty_d   = '0;
                    target_d = '0;
                end
            endcase
        end

        ready_d       = (state_d != S_BRAKE) && (state_d != S_WAIT_STOP);
        ramp_active_d = (duty_d != target_d);
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            presc_q       <= '0;
            wait_q        <= '0;
            enable_q      <= 1'b0;
            dir_q         <= DIR_NONE;
            pend_dir_q    <= DIR_NONE;
            duty_q        <= '0;
            target_q      <= '0;
            cmd_tgt_q     <= '0;
            ramp_active_q <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            wait_q        <= wait_d;
            enable_q      <= enable_d;
            dir_q         <= dir_d;
            pend_dir_q    <= pend_dir_d;
            duty_q        <= duty_d;
            target_q      <= target_d;
            cmd_tgt_q     <= cmd_tgt_d;
            ramp_active_q <= ramp_active_d;
            ready_q       <= ready_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign enable      = enable_q;
    assign direction   = dir_q;
    assign pwm_duty    = duty_q;
    assign ramp_active = ramp_active_q;
    assign ramp_state  = state_q;

endmodule
